// File: rtl/cr_crcgc_ob_frmchk_pkg.sv
// Shared definitions for the outbound frame checker and the stats block that
// consumes its summaries and event pulses.
package cr_crcgc_ob_frmchk_pkg;

    localparam int SUM_TID_W = 1;
    localparam int SUM_CNT_W = 24;

    // Bit positions inside sum_err
    localparam int ERR_NONCONTIG = 0;
    localparam int ERR_PARTIAL   = 1;
    localparam int ERR_TID       = 2;
    localparam int ERR_W         = 3;

    // Bit positions inside stat_events
    localparam int EV_GOOD = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_SAT  = 2;
    localparam int EV_W    = 3;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_IN_FRM = 1'b1;

    typedef logic [ERR_W-1:0] frm_err_t;
    typedef logic [EV_W-1:0]  frm_ev_t;

    typedef struct packed {
        logic [SUM_TID_W-1:0] tid;
        logic [SUM_CNT_W-1:0] bytes;
        logic [SUM_CNT_W-1:0] beats;
        frm_err_t             err;
    } frm_sum_t;

endpackage

// File: rtl/cr_crcgc_skid.sv
// Generic 2-entry AXI4-Stream skid buffer: main register drives the output,
// skid register absorbs the one beat that arrives after downstream stalls.
module cr_crcgc_skid #(
    parameter int PAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [PAY_W-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [PAY_W-1:0] m_data_o
);

    logic             main_vld_q, main_vld_d;
    logic [PAY_W-1:0] main_dat_q, main_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [PAY_W-1:0] skid_dat_q, skid_dat_d;
    logic             rdy_q, rdy_d;
    logic             accept;
    logic             main_free;

    assign accept    = s_valid_i & rdy_q;
    assign main_free = ~main_vld_q | m_ready_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (main_free) begin
            if (skid_vld_q) begin
                // Older beat moves up first; anything arriving now waits behind it.
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = accept;
                if (accept) begin
                    skid_dat_d = s_data_i;
                end
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_dat_d = s_data_i;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = s_data_i;
        end
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_ready_o = rdy_q;
    assign m_valid_o = main_vld_q;
    assign m_data_o  = main_dat_q;

endmodule

// File: rtl/cr_crcgc_ob_frmchk.sv
// Outbound frame checker: passes the CRC core's TLV stream through a skid
// buffer and summarises each accepted tlast-delimited frame for the stats block.
module cr_crcgc_ob_frmchk
    import cr_crcgc_ob_frmchk_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STRB_W = 8,
    parameter int TID_W  = 1,
    parameter int USER_W = 8,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ib_tvalid,
    output logic              ib_tready,
    input  logic              ib_tlast,
    input  logic [TID_W-1:0]  ib_tid,
    input  logic [STRB_W-1:0] ib_tstrb,
    input  logic [USER_W-1:0] ib_tuser,
    input  logic [DATA_W-1:0] ib_tdata,
    output logic              ob_tvalid,
    output logic              ob_tlast,
    output logic [TID_W-1:0]  ob_tid,
    output logic [STRB_W-1:0] ob_tstrb,
    output logic [USER_W-1:0] ob_tuser,
    output logic [DATA_W-1:0] ob_tdata,
    input  logic              ob_tready,
    input  logic              chk_en,
    output logic              sum_valid,
    output logic [TID_W-1:0]  sum_tid,
    output logic [CNT_W-1:0]  sum_bytes,
    output logic [CNT_W-1:0]  sum_beats,
    output logic [2:0]        sum_err,
    output logic [2:0]        stat_events
);

    localparam int PAY_W = 1 + TID_W + STRB_W + USER_W + DATA_W;
    localparam int PC_W  = $clog2(STRB_W + 1);
    localparam int ACC_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [PC_W-1:0] popcnt(input logic [STRB_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // MSB of the result flags that the true sum exceeded the counter range.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
        logic [ACC_W-1:0] s;
        s = ACC_W'(a) + ACC_W'(b);
        if (s > ACC_W'(CNT_MAX)) begin
            return {1'b1, CNT_MAX};
        end
        return {1'b0, s[CNT_W-1:0]};
    endfunction

    logic [PAY_W-1:0] pay_in, pay_out;

    cr_crcgc_skid #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (ib_tvalid),
        .s_ready_o (ib_tready),
        .s_data_i  (pay_in),
        .m_valid_o (ob_tvalid),
        .m_ready_i (ob_tready),
        .m_data_o  (pay_out)
    );

    assign pay_in = {ib_tlast, ib_tid, ib_tstrb, ib_tuser, ib_tdata};
    assign {ob_tlast, ob_tid, ob_tstrb, ob_tuser, ob_tdata} = pay_out;

    logic              state_q, state_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [CNT_W-1:0]  bytes_q, bytes_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    frm_err_t          err_q, err_d;
    logic              sat_seen_q, sat_seen_d;

    logic              sum_valid_q;
    logic [TID_W-1:0]  sum_tid_q;
    logic [CNT_W-1:0]  sum_bytes_q;
    logic [CNT_W-1:0]  sum_beats_q;
    frm_err_t          sum_err_q;
    frm_ev_t           stat_q, stat_d;

    logic              acc, upd, first_beat, sum_fire;
    logic [PC_W-1:0]   beat_bytes;
    logic [STRB_W-1:0] strb_inc;
    frm_err_t          beat_err, err_base, err_new;
    logic [TID_W-1:0]  tid_base;
    logic [CNT_W-1:0]  bytes_base, beats_base;
    logic [CNT_W:0]    bytes_sum, beats_sum;
    logic              sat_base, sat_now;

    assign acc        = ib_tvalid & ib_tready;
    assign upd        = acc & chk_en;
    assign first_beat = (state_q == ST_IDLE);
    assign sum_fire   = upd & ib_tlast;

    assign beat_bytes = popcnt(ib_tstrb);
    assign strb_inc   = ib_tstrb + STRB_W'(1);

    // A first beat starts from zero; later beats build on the running frame state.
    assign tid_base   = first_beat ? ib_tid : tid_q;
    assign bytes_base = first_beat ? '0 : bytes_q;
    assign beats_base = first_beat ? '0 : beats_q;
    assign err_base   = first_beat ? '0 : err_q;
    assign sat_base   = ~first_beat & sat_seen_q;

    always_comb begin
        beat_err = '0;
        // 2^k-1 patterns have no bit in common with their increment.
        beat_err[ERR_NONCONTIG] = (ib_tstrb != '0) && ((ib_tstrb & strb_inc) != '0);
        beat_err[ERR_PARTIAL]   = ~ib_tlast & (ib_tstrb != '1);
        beat_err[ERR_TID]       = (ib_tid != tid_base);
    end

    assign bytes_sum = sat_add(bytes_base, beat_bytes);
    assign beats_sum = sat_add(beats_base, PC_W'(1));
    assign err_new   = err_base | beat_err;
    assign sat_now   = bytes_sum[CNT_W] | beats_sum[CNT_W];

    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        bytes_d    = bytes_q;
        beats_d    = beats_q;
        err_d      = err_q;
        sat_seen_d = sat_seen_q;
        if (upd) begin
            tid_d      = tid_base;
            bytes_d    = bytes_sum[CNT_W-1:0];
            beats_d    = beats_sum[CNT_W-1:0];
            err_d      = err_new;
            sat_seen_d = sat_base | sat_now;
            state_d    = ib_tlast ? ST_IDLE : ST_IN_FRM;
        end else if (acc && ib_tlast) begin
            // Monitor disabled on the closing beat: drop the frame silently.
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        stat_d          = '0;
        stat_d[EV_GOOD] = sum_fire & (err_new == '0);
        stat_d[EV_ERR]  = sum_fire & (err_new != '0);
        stat_d[EV_SAT]  = upd & sat_now & ~sat_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tid_q      <= '0;
            bytes_q    <= '0;
            beats_q    <= '0;
            err_q      <= '0;
            sat_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            bytes_q    <= bytes_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
            sat_seen_q <= sat_seen_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid_q <= 1'b0;
            sum_tid_q   <= '0;
            sum_bytes_q <= '0;
            sum_beats_q <= '0;
            sum_err_q   <= '0;
            stat_q      <= '0;
        end else begin
            sum_valid_q <= sum_fire;
            stat_q      <= stat_d;
            if (sum_fire) begin
                sum_tid_q   <= tid_d;
                sum_bytes_q <= bytes_d;
                sum_beats_q <= beats_d;
                sum_err_q   <= err_d;
            end
        end
    end

    assign sum_valid   = sum_valid_q;
    assign sum_tid     = sum_tid_q;
    assign sum_bytes   = sum_bytes_q;
    assign sum_beats   = sum_beats_q;
    assign sum_err     = sum_err_q;
    assign stat_events = stat_q;

endmodule

// File: tb/tb_cr_crcgc_ob_frmchk.sv
// Bench for cr_crcgc_ob_frmchk: a 24-bit and a 4-bit counter instance share
// stimulus; a queue/arithmetic model tracks both alongside directed tables.
module tb_cr_crcgc_ob_frmchk;

    logic        clk = 1'b0;
    logic        rst;
    logic        ib_tvalid, ib_tlast, ib_tid, chk_en, ob_tready;
    logic [7:0]  ib_tstrb, ib_tuser;
    logic [63:0] ib_tdata;

    logic        ib_tready, ob_tvalid, ob_tlast, ob_tid, sum_valid, sum_tid;
    logic [7:0]  ob_tstrb, ob_tuser;
    logic [63:0] ob_tdata;
    logic [23:0] sum_bytes, sum_beats;
    logic [2:0]  sum_err, stat;

    logic        ib_tready4, ob_tvalid4, ob_tlast4, ob_tid4, sum_valid4, sum_tid4;
    logic [7:0]  ob_tstrb4, ob_tuser4;
    logic [63:0] ob_tdata4;
    logic [3:0]  sum_bytes4, sum_beats4;
    logic [2:0]  sum_err4, stat4;

    always #5 clk = ~clk;

    cr_crcgc_ob_frmchk dut (
        .clk(clk), .rst(rst), .ib_tvalid(ib_tvalid), .ib_tready(ib_tready),
        .ib_tlast(ib_tlast), .ib_tid(ib_tid), .ib_tstrb(ib_tstrb), .ib_tuser(ib_tuser),
        .ib_tdata(ib_tdata), .ob_tvalid(ob_tvalid), .ob_tlast(ob_tlast), .ob_tid(ob_tid),
        .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tdata(ob_tdata), .ob_tready(ob_tready),
        .chk_en(chk_en), .sum_valid(sum_valid), .sum_tid(sum_tid), .sum_bytes(sum_bytes),
        .sum_beats(sum_beats), .sum_err(sum_err), .stat_events(stat)
    );

    cr_crcgc_ob_frmchk #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ib_tvalid(ib_tvalid), .ib_tready(ib_tready4),
        .ib_tlast(ib_tlast), .ib_tid(ib_tid), .ib_tstrb(ib_tstrb), .ib_tuser(ib_tuser),
        .ib_tdata(ib_tdata), .ob_tvalid(ob_tvalid4), .ob_tlast(ob_tlast4), .ob_tid(ob_tid4),
        .ob_tstrb(ob_tstrb4), .ob_tuser(ob_tuser4), .ob_tdata(ob_tdata4), .ob_tready(ob_tready),
        .chk_en(chk_en), .sum_valid(sum_valid4), .sum_tid(sum_tid4), .sum_bytes(sum_bytes4),
        .sum_beats(sum_beats4), .sum_err(sum_err4), .stat_events(stat4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_contig(input logic [7:0] s);
        for (int k = 1; k <= 8; k++) begin
            if (int'(s) == (1 << k) - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: beats in flight, running true frame totals, expected outputs.
    typedef logic [81:0] pay_t;
    pay_t        q[$];
    int          since = 0;
    bit          in_frm;
    logic        ftid;
    int          fbytes, fbeats;
    logic [2:0]  ferr;
    bit          satf[2];
    int          maxv[2] = '{16777215, 15};
    logic        exp_sv;
    logic [2:0]  exp_stat[2];
    logic        exp_tid;
    logic [2:0]  exp_err;
    int          exp_bytes[2], exp_beats[2];
    int          sat_cnt = 0, sat4_cnt = 0;

    always @(negedge clk) begin : scoreboard
        bit exp_rdy, acc;
        if (rst) begin
            chk("rst_ib_tready", 128'(ib_tready), 128'(0));
            chk("rst_ob_tvalid", 128'(ob_tvalid), 128'(0));
            chk("rst_ob_tdata", 128'(ob_tdata), 128'(0));
            chk("rst_sum_valid", 128'(sum_valid), 128'(0));
            chk("rst_sum_bytes", 128'(sum_bytes), 128'(0));
            chk("rst_stat", 128'(stat), 128'(0));
            q.delete();
            since = 0; in_frm = 0; exp_sv = 0;
            exp_stat[0] = '0; exp_stat[1] = '0;
            exp_tid = 0; exp_err = '0;
            exp_bytes = '{0, 0}; exp_beats = '{0, 0};
        end else begin
            exp_rdy = (since >= 1) && (q.size() < 2);
            chk("ib_tready", 128'(ib_tready), 128'(exp_rdy));
            chk("ib_tready_c4", 128'(ib_tready4), 128'(exp_rdy));
            chk("ob_tvalid", 128'(ob_tvalid), 128'(q.size() > 0));
            chk("ob_tvalid_c4", 128'(ob_tvalid4), 128'(q.size() > 0));
            if (q.size() > 0) begin
                chk("ob_side", 128'({ob_tlast, ob_tid, ob_tstrb, ob_tuser}), 128'(q[0][81:64]));
                chk("ob_tdata", 128'(ob_tdata), 128'(q[0][63:0]));
            end
            chk("sum_valid", 128'(sum_valid), 128'(exp_sv));
            chk("sum_valid_c4", 128'(sum_valid4), 128'(exp_sv));
            chk("stat_events", 128'(stat), 128'(exp_stat[0]));
            chk("stat_events_c4", 128'(stat4), 128'(exp_stat[1]));
            chk("sum_tid", 128'({sum_tid, sum_tid4}), 128'({exp_tid, exp_tid}));
            chk("sum_err", 128'({sum_err, sum_err4}), 128'({exp_err, exp_err}));
            chk("sum_bytes", 128'(sum_bytes), 128'(exp_bytes[0]));
            chk("sum_beats", 128'(sum_beats), 128'(exp_beats[0]));
            chk("sum_bytes_c4", 128'(sum_bytes4), 128'(exp_bytes[1]));
            chk("sum_beats_c4", 128'(sum_beats4), 128'(exp_beats[1]));
            if (stat[2])  sat_cnt++;
            if (stat4[2]) sat4_cnt++;

            since++;
            acc = ib_tvalid && exp_rdy;
            exp_sv = 0;
            exp_stat[0] = '0; exp_stat[1] = '0;
            if (q.size() > 0 && ob_tready) void'(q.pop_front());
            if (acc) begin
                q.push_back({ib_tlast, ib_tid, ib_tstrb, ib_tuser, ib_tdata});
                if (chk_en) begin
                    if (!in_frm) begin
                        ftid = ib_tid; fbytes = 0; fbeats = 0; ferr = '0;
                        satf = '{0, 0};
                    end else if (ib_tid != ftid) begin
                        ferr[2] = 1'b1;
                    end
                    fbytes += $countones(ib_tstrb);
                    fbeats++;
                    if (ib_tstrb != 8'h00 && !is_contig(ib_tstrb)) ferr[0] = 1'b1;
                    if (!ib_tlast && ib_tstrb != 8'hFF) ferr[1] = 1'b1;
                    for (int w = 0; w < 2; w++) begin
                        if (!satf[w] && (fbytes > maxv[w] || fbeats > maxv[w])) begin
                            satf[w] = 1;
                            exp_stat[w][2] = 1'b1;
                        end
                    end
                    if (ib_tlast) begin
                        exp_sv = 1; exp_tid = ftid; exp_err = ferr;
                        for (int w = 0; w < 2; w++) begin
                            exp_bytes[w] = (fbytes > maxv[w]) ? maxv[w] : fbytes;
                            exp_beats[w] = (fbeats > maxv[w]) ? maxv[w] : fbeats;
                            exp_stat[w][0] = (ferr == 3'b000);
                            exp_stat[w][1] = (ferr != 3'b000);
                        end
                        in_frm = 0;
                    end else begin
                        in_frm = 1;
                    end
                end else if (ib_tlast) begin
                    in_frm = 0;
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] strb, input logic tid, input logic last,
                             output logic [63:0] dat);
        int n = 0;
        dat = {$urandom, $urandom};
        ib_tvalid = 1'b1; ib_tstrb = strb; ib_tid = tid; ib_tlast = last;
        ib_tuser = 8'($urandom); ib_tdata = dat;
        while (!ib_tready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 128'(n < 50), 128'(1));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] strb;
        logic       tid;
        logic       last;
        logic       stid;
        int         bytes;
        int         beats;
        logic [2:0] err;
        int         bytes4;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] s, input logic t, input logic l,
                                input logic st, input int by, input int be,
                                input logic [2:0] e, input int by4);
        vec_t v;
        v.strb = s; v.tid = t; v.last = l; v.stid = st;
        v.bytes = by; v.beats = be; v.err = e; v.bytes4 = by4;
        return v;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        tbl[14];
        logic [63:0] dat;
        logic [63:0] d[4], rec[4];
        int          idx, got, c0, c4;
        bit          adv;
        logic [8:0]  cm;

        // Summary fields only matter on rows with last=1.
        tbl[0]  = mk(8'hFF, 1, 0, 0,  0, 0, 3'b000,  0);
        tbl[1]  = mk(8'hFF, 1, 0, 0,  0, 0, 3'b000,  0);
        tbl[2]  = mk(8'h0F, 1, 1, 1, 20, 3, 3'b000, 15);
        tbl[3]  = mk(8'hFF, 0, 0, 0,  0, 0, 3'b000,  0);
        tbl[4]  = mk(8'h3F, 0, 0, 0,  0, 0, 3'b000,  0);
        tbl[5]  = mk(8'hFF, 0, 1, 0, 22, 3, 3'b010, 15);
        tbl[6]  = mk(8'hFF, 0, 0, 0,  0, 0, 3'b000,  0);
        tbl[7]  = mk(8'hFF, 1, 0, 0,  0, 0, 3'b000,  0);
        tbl[8]  = mk(8'h05, 0, 1, 0, 18, 3, 3'b101, 15);
        tbl[9]  = mk(8'h01, 1, 1, 1,  1, 1, 3'b000,  1);
        tbl[10] = mk(8'hFF, 0, 0, 0,  0, 0, 3'b000,  0);
        tbl[11] = mk(8'h00, 0, 0, 0,  0, 0, 3'b000,  0);
        tbl[12] = mk(8'h03, 0, 1, 0, 10, 3, 3'b010, 10);
        tbl[13] = mk(8'h00, 0, 1, 0,  0, 1, 3'b000,  0);

        rst = 1'b1; ib_tvalid = 0; ib_tlast = 0; ib_tid = 0; ib_tstrb = 0;
        ib_tuser = 0; ib_tdata = 0; chk_en = 1; ob_tready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed frames, back to back, with latency and summary checks.
        foreach (tbl[i]) begin
            send_beat(tbl[i].strb, tbl[i].tid, tbl[i].last, dat);
            chk("lat_valid", 128'(ob_tvalid), 128'(1));
            chk("lat_data", 128'(ob_tdata), 128'(dat));
            if (tbl[i].last) begin
                chk("tbl_sum_valid", 128'(sum_valid), 128'(1));
                chk("tbl_sum_tid", 128'(sum_tid), 128'(tbl[i].stid));
                chk("tbl_sum_bytes", 128'(sum_bytes), 128'(tbl[i].bytes));
                chk("tbl_sum_beats", 128'(sum_beats), 128'(tbl[i].beats));
                chk("tbl_sum_err", 128'(sum_err), 128'(tbl[i].err));
                chk("tbl_sum_bytes_c4", 128'(sum_bytes4), 128'(tbl[i].bytes4));
                chk("tbl_stat", 128'(stat),
                    128'({1'b0, tbl[i].err != 3'b000, tbl[i].err == 3'b000}));
            end
        end
        ib_tvalid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 4 beats offered against a stalled sink.
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        idx = 0; ob_tready = 0;
        ib_tvalid = 1; ib_tlast = 1; ib_tid = 0; ib_tstrb = 8'hFF; ib_tdata = d[0];
        repeat (6) begin
            adv = ib_tvalid && ib_tready;
            @(posedge clk); #1;
            if (adv) begin
                idx++;
                if (idx < 4) ib_tdata = d[idx]; else ib_tvalid = 0;
            end
        end
        chk("bp_accepted", 128'(idx), 128'(2));
        chk("bp_tready", 128'(ib_tready), 128'(0));
        chk("bp_head", 128'(ob_tdata), 128'(d[0]));
        ob_tready = 1; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (ob_tvalid) begin
                rec[got] = ob_tdata;
                got++;
            end
            adv = ib_tvalid && ib_tready;
            @(posedge clk); #1;
            if (adv) begin
                idx++;
                if (idx < 4) ib_tdata = d[idx]; else ib_tvalid = 0;
            end
        end
        chk("bp_drained", 128'(got), 128'(4));
        for (int i = 0; i < 4; i++) chk("bp_order", 128'(rec[i]), 128'(d[i]));
        ib_tvalid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Counter saturation on the 4-bit instance: one event for the frame.
        c0 = sat_cnt; c4 = sat4_cnt;
        send_beat(8'hFF, 0, 0, dat);
        send_beat(8'hFF, 0, 0, dat);
        send_beat(8'hFF, 0, 1, dat);
        ib_tvalid = 0;
        chk("sat_bytes", 128'(sum_bytes), 128'(24));
        chk("sat_bytes_c4", 128'(sum_bytes4), 128'(15));
        chk("sat_beats_c4", 128'(sum_beats4), 128'(3));
        @(negedge clk); @(negedge clk);
        chk("sat_events_c4", 128'(sat4_cnt - c4), 128'(1));
        chk("sat_events", 128'(sat_cnt - c0), 128'(0));
        @(posedge clk); #1;

        // Monitor paused on a middle beat, then disabled on a closing beat.
        send_beat(8'hFF, 0, 0, dat);
        chk_en = 0;
        send_beat(8'hFF, 0, 0, dat);
        chk_en = 1;
        send_beat(8'h03, 0, 1, dat);
        chk("freeze_bytes", 128'(sum_bytes), 128'(10));
        chk("freeze_beats", 128'(sum_beats), 128'(2));
        chk("freeze_err", 128'(sum_err), 128'(0));
        send_beat(8'hFF, 1, 0, dat);
        chk_en = 0;
        send_beat(8'h0F, 1, 1, dat);
        chk("suppress_valid", 128'(sum_valid), 128'(0));
        chk_en = 1; ib_tvalid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame, then a fresh single-beat frame.
        send_beat(8'hFF, 0, 0, dat);
        send_beat(8'hFF, 0, 0, dat);
        ib_tvalid = 0;
        rst = 1;
        #1;
        chk("mrst_ob_tvalid", 128'(ob_tvalid), 128'(0));
        chk("mrst_ib_tready", 128'(ib_tready), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("mrst_sum_bytes", 128'(sum_bytes), 128'(0));
        send_beat(8'h01, 1, 1, dat);
        ib_tvalid = 0;
        chk("mrst_sum_valid", 128'(sum_valid), 128'(1));
        chk("mrst_sum_bytes1", 128'(sum_bytes), 128'(1));
        chk("mrst_sum_beats1", 128'(sum_beats), 128'(1));
        chk("mrst_sum_err", 128'(sum_err), 128'(0));
        chk("mrst_stat", 128'(stat), 128'(3'b001));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            ib_tvalid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0, 1: ib_tstrb = 8'hFF;
                2: begin
                    cm = (9'd1 << $urandom_range(0, 8)) - 9'd1;
                    ib_tstrb = cm[7:0];
                end
                default: ib_tstrb = 8'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) ib_tid = ~ib_tid;
            ib_tlast  = ($urandom_range(0, 3) == 0);
            chk_en    = ($urandom_range(0, 9) != 0);
            ob_tready = ($urandom_range(0, 3) != 0);
            ib_tuser  = 8'($urandom);
            ib_tdata  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        ib_tvalid = 0; ob_tready = 1; chk_en = 1;
        repeat (6) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
